// File: rtl/sqrt_pipe_ctrl.sv
// sqrt_pipe_ctrl: sequencing FSM for the two-stage pipelined square-root datapath.
// Optional iteration watchdog enabled by defining SQRT_CTRL_TIMEOUT_EN.
module sqrt_pipe_ctrl #(
  parameter int MAX_ITER = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] valor_i,
  output logic [15:0] dp_valor_o,
  output logic        dp_wr_input_o,
  output logic        dp_wr_square_o,
  output logic        dp_en_pipe_o,
  output logic        dp_ready_o,
  output logic        dp_mux_root_o,
  input  logic        dp_N_i,
  input  logic        dp_ready_i,
  input  logic [7:0]  dp_root_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  root_o,
  output logic        err_o
);
  typedef enum logic [2:0] {IDLE, LOAD, ITER_A, ITER_B, CORRECT, FLUSH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] valor_q;
  logic [7:0] root_q, root_d;
  logic to_hit;
  logic accept;
  if (MAX_ITER < 2 || MAX_ITER > 256) begin : g_bad_max_iter
    $error("MAX_ITER out of range 2..256");
  end
  assign accept = (state_q == IDLE) && in_valid_i;
`ifdef SQRT_CTRL_TIMEOUT_EN
  logic [8:0] cnt_q, cnt_d;
  logic err_q;
  assign to_hit = cnt_q == 9'(MAX_ITER - 1);
  assign cnt_d = (state_q == LOAD) ? '0 : (state_q == ITER_B) ? cnt_q + 9'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) err_q <= 1'b0;
      else if (state_q == ITER_B && !dp_N_i && to_hit) err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  assign to_hit = 1'b0;
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    root_d = root_q;
    case (state_q)
      IDLE:    state_d = in_valid_i ? LOAD : IDLE;
      LOAD:    state_d = ITER_A;
      ITER_A:  state_d = ITER_B;
      ITER_B: begin
        state_d = dp_N_i ? CORRECT : to_hit ? DONE : ITER_A;
        root_d = (!dp_N_i && to_hit) ? 8'hFF : root_q;
      end
      CORRECT: state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN: begin
        state_d = dp_ready_i ? DONE : DRAIN;
        root_d = dp_ready_i ? dp_root_i : root_q;
      end
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valor_q <= '0;
      root_q <= '0;
    end else begin
      state_q <= state_d;
      root_q <= root_d;
      if (accept) valor_q <= valor_i;
    end
  end
  assign in_ready_o = state_q == IDLE;
  assign dp_valor_o = in_ready_o ? valor_i : valor_q;
  assign dp_wr_input_o = state_q == LOAD;
  assign dp_wr_square_o = state_q == ITER_B;
  assign dp_en_pipe_o = state_q inside {LOAD, ITER_A, ITER_B, CORRECT, FLUSH};
  assign dp_mux_root_o = state_q == CORRECT;
  assign dp_ready_o = state_q == FLUSH;
  assign out_valid_o = state_q == DONE;
  assign root_o = root_q;
endmodule
